// File: rtl/skid_pkg.sv
// Shared types for the two-entry skid buffer: state encoding and main-register mux selects.
// Pure declarations; no logic.
package skid_pkg;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_BUSY  = 2'b01,
    SB_FULL  = 2'b10
  } sb_state_t;

  localparam logic SB_SEL_IN   = 1'b0;
  localparam logic SB_SEL_SKID = 1'b1;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 mux: y = sel ? b : a.
// Purely combinational, no backpressure involvement.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/skid_buffer_dff_en.sv
// WIDTH-wide register with load enable and asynchronous active-low clear.
// Captures d_i on the edge where en_i is high, otherwise holds.
module dff_en #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry registered skid buffer: 1-cycle latency, full throughput, ready/valid both sides.
// in_ready and out_valid decode from the state register only, so no input-to-output path exists.
module skid_buffer
  import skid_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  sb_state_t        state_q, state_d;
  logic             main_en, skid_en, main_sel;
  logic             in_fire, out_fire;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the register load controls that accompany each transition.
  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_sel = SB_SEL_IN;
    case (state_q)
      SB_EMPTY: begin
        if (in_valid) begin
          main_en = 1'b1;
          state_d = SB_BUSY;
        end
      end
      SB_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = SB_FULL;
        end else if (out_fire) begin
          state_d = SB_EMPTY;
        end
      end
      SB_FULL: begin
        if (out_fire) begin
          main_en  = 1'b1;
          main_sel = SB_SEL_SKID;
          state_d  = SB_BUSY;
        end
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != SB_EMPTY);
    in_ready  = (state_q != SB_FULL);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_main_mux
    mux2_1 u_mux (
      .a   (in_data[i]),
      .b   (skid_q[i]),
      .sel (main_sel),
      .y   (main_d[i])
    );
  end

  dff_en #(.WIDTH(WIDTH)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (main_en),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  dff_en #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (skid_en),
    .d_i     (in_data),
    .q_o     (skid_q)
  );

  assign out_data = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_skid_buffer;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             exp_ov;
    logic [WIDTH-1:0] exp_od;
    logic             exp_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                         input logic eov, input logic [WIDTH-1:0] eod, input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.exp_ov = eov; v.exp_od = eod; v.exp_ir = eir;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] prev_od;
  logic             prev_stall;
  int               accepted;
  int               delivered;

  initial begin
    // Reset with garbage on the inputs.
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hFFFF;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    reset_n = 1'b1;
    in_data = 64'hA5;
    step();
    chk("first_out_valid", {63'd0, out_valid}, 64'd1);
    chk("first_out_data",  out_data, 64'hA5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("first_drain_valid", {63'd0, out_valid}, 64'd0);

    // Table: inputs applied for one edge, outputs expected after that edge.
    add_vec(1, 1,  1, 1, 1,  1);
    add_vec(1, 2,  1, 1, 2,  1);
    add_vec(1, 3,  1, 1, 3,  1);
    add_vec(1, 4,  1, 1, 4,  1);
    add_vec(0, 0,  1, 0, 0,  1);
    add_vec(1, 10, 0, 1, 10, 1);
    add_vec(1, 11, 0, 1, 10, 0);
    add_vec(1, 12, 0, 1, 10, 0);
    add_vec(1, 12, 1, 1, 11, 1);
    add_vec(1, 12, 1, 1, 12, 1);
    add_vec(0, 0,  1, 0, 0,  1);
    add_vec(1, 7,  0, 1, 7,  1);
    add_vec(0, 0,  1, 0, 0,  1);
    add_vec(0, 0,  1, 0, 0,  1);
    add_vec(1, 5,  1, 1, 5,  1);
    add_vec(0, 0,  0, 1, 5,  1);
    add_vec(0, 0,  1, 0, 0,  1);
    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      step();
      chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].exp_ir});
      if (vecs[i].exp_ov) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
    end

    // Async reset while FULL: must clear without a clock edge.
    in_valid = 1'b1; out_ready = 1'b0; in_data = 20;
    step();
    in_data = 21;
    step();
    in_valid = 1'b0;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_out_data", out_data, 64'd20);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready",  {63'd0, in_ready}, 64'd1);
    chk("arst_out_data",  out_data, 64'd0);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arst_after%0d_valid", k), {63'd0, out_valid}, 64'd0);
    end

    // Randomized traffic against a queue model of capacity two.
    do_reset();
    accepted = 0; delivered = 0; prev_stall = 1'b0; prev_od = '0;
    for (int c = 0; c < 1000; c++) begin
      logic iv, ordy, m_in, m_out;
      chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
      chk("rnd_in_ready",  {63'd0, in_ready},  {63'd0, model_q.size() < 2});
      if (model_q.size() > 0) chk("rnd_out_data", out_data, model_q[0]);
      if (prev_stall) chk("rnd_stall_stable", out_data, prev_od);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      in_valid  = iv;
      in_data   = {$urandom, $urandom};
      out_ready = ordy;
      m_in  = iv && (model_q.size() < 2);
      m_out = ordy && (model_q.size() > 0);
      if (out_valid && out_ready) delivered++;
      prev_stall = out_valid && !out_ready;
      prev_od    = out_data;
      if (m_out) void'(model_q.pop_front());
      if (m_in) begin
        model_q.push_back(in_data);
        accepted++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) delivered++;
      step();
    end
    chk("rnd_count", 64'(delivered), 64'(accepted));
    chk("rnd_final_empty", {63'd0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Two-entry registered skid buffer with valid/ready handshake on both sides.
- Cuts the combinational ready path between pipeline stages while sustaining one transfer per cycle.
- Sits directly upstream of the 2:1 mux datapath. Its own main-register load path is a WIDTH-wide bank of mux2_1 instances selecting in_data or skid data.
- Feeds out_data to the next stage's operand muxes.

Parameters:
WIDTH, 64, data word width in bits (>= 1)

Ports:
clk  input  1  rising-edge clock, single clock domain
reset_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  upstream data word
in_valid  input  1  upstream word valid
in_ready  output  1  buffer can accept a word this cycle
out_data  output  WIDTH  downstream data word (main register)
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts this cycle

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). Assertion clears state immediately, with no clk edge. Deassertion is synchronous to clk by the integrator.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data), skid register, 2-bit state.
- States: EMPTY (no data), BUSY (main valid), FULL (main and skid valid).
- Outputs are decoded from the state register only, with no combinational path from any input:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL)
- Reset values: state=EMPTY, main=0, skid=0, out_valid=0, out_data=0, in_ready=1. All hold for as long as reset_n is low.
- EMPTY:
  - in_valid: main<=in_data, go to BUSY.
  - otherwise: stay in EMPTY.
  - out_ready is ignored.
- BUSY:
  - in_fire & out_fire: main<=in_data, stay in BUSY (full throughput).
  - in_fire & !out_fire: skid<=in_data, go to FULL.
  - !in_fire & out_fire: go to EMPTY. main keeps its stale value, which must not be relied on.
  - neither: hold.
- FULL:
  - in_ready=0, so in_valid is ignored and in_data is never captured.
  - out_fire: main<=skid (mux select = 1), go to BUSY.
  - otherwise: hold both registers.
- Main-register input mux select is 1 only on the FULL->BUSY transition, else 0. The register enable is asserted only on the loads listed above.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N (1 cycle) when the buffer is EMPTY or streaming.
- Ordering: strict FIFO order, no drops, no duplicates.
- Stall behaviour: while out_valid=1 and out_ready=0, out_data is stable.
- Reset mid-operation: both entries are discarded, and the buffer returns to EMPTY with in_ready=1.
- The illegal state encoding (2'b11) recovers to EMPTY on the next edge.

Decomposition:
- Shared package skid_pkg:
  - enum sb_state_t {SB_EMPTY=2'b00, SB_BUSY=2'b01, SB_FULL=2'b10}
  - localparam SB_SEL_IN=1'b0, SB_SEL_SKID=1'b1
- Datapath reuses the existing mux2_1 per bit through a generate loop; no new mux module.
- One natural sub-module: dff_en (WIDTH-parameterised enabled register with async active-low clear). It is instantiated twice, for main and skid.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1, in_data=64'hFFFF. Required: out_valid=0, out_data=0, in_ready=1. Then release reset_n, present in_data=64'hA5, in_valid=1 for one edge. Required: out_data=64'hA5, out_valid=1 next cycle.
- Streaming: out_ready=1 constant, send 1,2,3,4 on consecutive cycles. Required: out_data shows 1,2,3,4 on consecutive cycles, in_ready stays 1, and nothing is lost.
- Skid fill: out_ready=0, send 10 then 11. Required: state FULL and in_ready=0. Then send 12 while stalled; it is not accepted. Raise out_ready: outputs are 10, then 11, then in_ready=1 and 12 is accepted.
- Drain: from BUSY with out_data=7, drop in_valid and pulse out_ready. Required: out_valid=0 next cycle, in_ready=1.
- Async reset mid-FULL: hold entries 20 and 21, then pulse reset_n low between clock edges. Required: out_valid=0 immediately, and 20/21 never appear afterwards.
- Random: 1000 cycles of random in_valid/out_ready, checked against a scoreboard queue. Required: exact order and count match, and out_data is stable during every stall.
